uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, brg_stb_i strobes per bit (even, 8..32).
REQ-003 SHALL have port clk_i  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port brg_stb_i  input  1  one-clk oversample strobe from fracbrg brg_stb_o.
REQ-006 SHALL have port rxd_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port ack_i  input  1  consumer acknowledge, clears vld_o.
REQ-008 SHALL have port dat_o  output  DATA_BITS  received word, LSB first on the line.
REQ-009 SHALL have port vld_o  output  1  dat_o holds an unacknowledged word.
REQ-010 SHALL have port ferr_o  output  1  framing error of the word in dat_o.
REQ-011 SHALL have port ovr_o  output  1  sticky overrun flag.
REQ-012 SHALL have port busy_o  output  1  high in any state except IDLE.

Function
REQ-013 SHALL pass rxd_i through a 2-FF synchronizer (both FFs reset to 1) before any use; 2-clk latency.
REQ-014 SHALL have FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 SHALL advance the tick counter (0..OVERSAMPLE-1, wraps to 0) only on clk edges with brg_stb_i=1; no activity otherwise.
REQ-016 IDLE: on strobe with synchronized rxd=0 -> START, counter=0.
REQ-017 Bit value SHALL be majority of samples at counts M-1, M, M+1 (M=OVERSAMPLE/2), decided on the M+1 strobe.
REQ-018 START: decided value 1 -> IDLE (glitch, no output); 0 -> DATA at counter wrap, bit index 0.
REQ-019 DATA: decided bit shifted in LSB-first; after bit DATA_BITS-1 -> PARITY (macro) or STOP at counter wrap.
REQ-020 STOP: on decision at M+1, enter IDLE same cycle; dat_o loaded, vld_o=1, ferr_o = NOT decided stop bit.
REQ-021 dat_o/ferr_o SHALL change only on word completion; hold otherwise.
REQ-022 vld_o SHALL clear on clk with ack_i=1; completion in same cycle as ack_i -> vld_o stays 1 with new word, no overrun.
REQ-023 Completion while vld_o=1 and ack_i=0 SHALL overwrite dat_o and set ovr_o; ovr_o cleared only by rst_i or by ack_i.
REQ-024 A frame with ferr_o=1 (incl. break, all zeros) SHALL still set vld_o; receiver SHALL wait for rxd=1 in IDLE before new start detection.

Reset
REQ-025 rst_i=1 SHALL force, on next edge: FSM IDLE, counter 0, dat_o 0, vld_o 0, ferr_o 0, ovr_o 0, busy_o 0, perr_o 0, synchronizer 1.
REQ-026 rst_i mid-frame SHALL abort the frame with no vld_o pulse; rst_i has priority over all inputs.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state after data bit, even parity checked by majority decision, output port perr_o 1 bit (loaded with dat_o, 1 = mismatch).
REQ-028 Macro undefined: no PARITY state, no perr_o port, frame = start + DATA_BITS + stop.

Verification
REQ-029 8N1, OVERSAMPLE=16, fracbrg 24 MHz/38400: send 0x55 then 0xA3 with ack after each -> dat_o 0x55 then 0xA3, ferr_o 0, ovr_o 0.
REQ-030 rxd low for 4 strobes then high -> busy_o returns 0 at count 9, vld_o never rises.
REQ-031 Send 0x3C with stop bit 0 -> vld_o 1, dat_o 0x3C, ferr_o 1; next byte 0x01 after idle received cleanly.
REQ-032 Send 0x11 and 0x22 without ack -> dat_o 0x22, ovr_o 1; ack_i -> vld_o 0, ovr_o 0.
REQ-033 rst_i asserted during data bit 3 of 0xFF -> all outputs 0 next edge; following 0x81 received correctly.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> perr_o 0; parity bit 0 -> perr_o 1.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling asynchronous serial receiver.
//
// Recovers LSB-first frames (start, DATA_BITS data, [parity], stop) from an
// idle-high line. Timing comes from an external oversample strobe (one clk
// wide, OVERSAMPLE strobes per bit). Each bit is the 2-of-3 majority of the
// samples taken at strobe counts M-1, M and M+1 (M = OVERSAMPLE/2). The
// detecting strobe of the start edge counts as 0.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit, checked into perr_o.
//
// Ports
//   clk_i      system clock, all state on the rising edge
//   rst_i      synchronous active-high reset, priority over all inputs
//   brg_stb_i  oversample strobe from the baud-rate generator
//   rxd_i      asynchronous serial line, idle high
//   ack_i      consumer acknowledge, clears vld_o and ovr_o
//   dat_o      last received word
//   vld_o      dat_o holds an unacknowledged word
//   ferr_o     framing error (stop bit sampled low) of the word in dat_o
//   ovr_o      sticky overrun: a word was overwritten before being acked
//   perr_o     parity mismatch of the word in dat_o (UART_RX_PARITY_EN only)
//   busy_o     receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 brg_stb_i,
  input  logic                 rxd_i,
  input  logic                 ack_i,
  output logic [DATA_BITS-1:0] dat_o,
  output logic                 vld_o,
  output logic                 ferr_o,
  output logic                 ovr_o,
`ifdef UART_RX_PARITY_EN
  output logic                 perr_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_SA  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_SB  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_DEC = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                 rxd_meta, rxd_s;
  logic [2:0]           state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n, cnt_inc;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic [1:0]           samp_q, samp_n;
  logic                 armed_q, armed_n;
  logic                 bit_val, done, busy_n;
  logic [DATA_BITS-1:0] dat_n;
  logic                 vld_n, ferr_n, ovr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_n, perr_n;
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    samp_n  = samp_q;
    armed_n = armed_q;
    dat_n   = dat_o;
    vld_n   = vld_o;
    ferr_n  = ferr_o;
    ovr_n   = ovr_o;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = perr_o;
`endif
    done    = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    // Majority of the two stored samples and the live one at count M+1.
    bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

    if (brg_stb_i) begin
      if (state_q != ST_IDLE) begin
        cnt_n = cnt_inc;
        if (cnt_inc == CNT_SA) samp_n[0] = rxd_s;
        if (cnt_inc == CNT_SB) samp_n[1] = rxd_s;
      end
      case (state_q)
        ST_IDLE: begin
          // Start detection re-arms only after the line has been seen high,
          // so a break or a low stop bit cannot retrigger a frame.
          if (rxd_s) begin
            armed_n = 1'b1;
          end else if (armed_q) begin
            state_n = ST_START;
            cnt_n   = '0;
          end
        end
        ST_START: begin
          if (cnt_inc == CNT_DEC && bit_val) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_n = ST_DATA;
            idx_n   = '0;
          end
        end
        ST_DATA: begin
          if (cnt_inc == CNT_DEC) begin
            shreg_n = {bit_val, shreg_q[DATA_BITS-1:1]};
          end else if (cnt_q == CNT_MAX) begin
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              idx_n = idx_q + IDX_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_inc == CNT_DEC) begin
            par_n = bit_val;
          end else if (cnt_q == CNT_MAX) begin
            state_n = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_inc == CNT_DEC) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            armed_n = 1'b0;
            done    = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    busy_n = (state_n != ST_IDLE);

    // Word completion wins over a plain ack; an ack in the same cycle only
    // suppresses the overrun.
    if (done) begin
      dat_n  = shreg_q;
      ferr_n = ~bit_val;
      vld_n  = 1'b1;
      ovr_n  = ack_i ? 1'b0 : (ovr_o | vld_o);
`ifdef UART_RX_PARITY_EN
      perr_n = ^{shreg_q, par_q};
`endif
    end else if (ack_i) begin
      vld_n = 1'b0;
      ovr_n = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      samp_q   <= '0;
      armed_q  <= 1'b0;
      dat_o    <= '0;
      vld_o    <= 1'b0;
      ferr_o   <= 1'b0;
      ovr_o    <= 1'b0;
      busy_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_o   <= 1'b0;
`endif
    end else begin
      rxd_meta <= rxd_i;
      rxd_s    <= rxd_meta;
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      shreg_q  <= shreg_n;
      samp_q   <= samp_n;
      armed_q  <= armed_n;
      dat_o    <= dat_n;
      vld_o    <= vld_n;
      ferr_o   <= ferr_n;
      ovr_o    <= ovr_n;
      busy_o   <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_n;
      perr_o   <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: strobe-locked line driver, table of frames with
// fixed expectations, hand sequences for glitch/break/reset/ack corners and
// randomized frames against a behavioural receive-buffer model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       brg_stb = 1'b0;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] dat;
  logic       vld, ferr, ovr, busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  logic       par_flip = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Strobe source: fractional 24 MHz / (38400*16) or random 3..5 clk period.
  logic frac_mode = 1'b0;
  int   acc = 0;
  int   gap = 0;

  // Behavioural model of the receive buffer.
  logic [7:0] m_dat = 8'h00;
  logic       m_vld = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack_after;
    logic [7:0] exp_dat;
    logic       exp_ferr;
    logic       exp_vld;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .brg_stb_i (brg_stb),
    .rxd_i     (rxd),
    .ack_i     (ack),
    .dat_o     (dat),
    .vld_o     (vld),
    .ferr_o    (ferr),
    .ovr_o     (ovr),
`ifdef UART_RX_PARITY_EN
    .perr_o    (perr),
`endif
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frac_mode) begin
      acc = acc + 16;
      if (acc >= 625) begin
        acc = acc - 625;
        brg_stb = 1'b1;
      end else begin
        brg_stb = 1'b0;
      end
    end else if (gap == 0) begin
      brg_stb = 1'b1;
      gap = int'($urandom_range(4, 2));
    end else begin
      brg_stb = 1'b0;
      gap = gap - 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns #1 after the n-th strobe edge.
  task automatic wait_stb(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!brg_stb) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rxd = v;
    wait_stb(n);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  // One frame; optional ack pulse exactly on the stop-bit decision strobe.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic ack_done);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ par_flip, 16);
`endif
    rxd = stop_bit;
    wait_stb(9);
    if (ack_done) begin
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        #1;
        if (brg_stb) break;
      end
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
    end else begin
      wait_stb(1);
    end
    wait_stb(6);
    rxd = 1'b1;
    wait_stb(2);
  endtask

  task automatic m_complete(input logic [7:0] d, input logic stop_bit, input logic ack_same);
    m_ovr  = ack_same ? 1'b0 : (m_ovr | m_vld);
    m_vld  = 1'b1;
    m_dat  = d;
    m_ferr = ~stop_bit;
  endtask

  task automatic m_ack();
    m_vld = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, " dat"},  32'(dat),  32'(m_dat));
    check({tag, " vld"},  32'(vld),  32'(m_vld));
    check({tag, " ferr"}, 32'(ferr), 32'(m_ferr));
    check({tag, " ovr"},  32'(ovr),  32'(m_ovr));
    check({tag, " busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs, ra;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b1};

    // Reset state.
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all("reset");
`ifdef UART_RX_PARITY_EN
    check("reset perr", 32'(perr), 32'(0));
`endif
    rst = 1'b0;
    wait_stb(3);

    // 8N1 at 24 MHz / 38400 with ack after each word.
    frac_mode = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    m_complete(8'h55, 1'b1, 1'b0);
    check_all("frac55");
    do_ack(); m_ack();
    check("frac55 ack vld", 32'(vld), 32'(0));
    send_frame(8'hA3, 1'b1, 1'b0);
    m_complete(8'hA3, 1'b1, 1'b0);
    check_all("fracA3");
    do_ack(); m_ack();
    frac_mode = 1'b0;
    wait_stb(2);

    // Table of frames with fixed expectations.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      check($sformatf("vec%0d dat", i),  32'(dat),  32'(vecs[i].exp_dat));
      check($sformatf("vec%0d ferr", i), 32'(ferr), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d vld", i),  32'(vld),  32'(vecs[i].exp_vld));
      check($sformatf("vec%0d ovr", i),  32'(ovr),  32'(vecs[i].exp_ovr));
      if (vecs[i].ack_after) begin
        do_ack();
        check($sformatf("vec%0d ack vld", i), 32'(vld), 32'(0));
        check($sformatf("vec%0d ack ovr", i), 32'(ovr), 32'(0));
      end
    end
    m_dat = 8'hFE; m_ferr = 1'b0; m_vld = 1'b0; m_ovr = 1'b0;

    // Start glitch: low for counts 0..3, rejected at count 9.
    rxd = 1'b0;
    wait_stb(1);
    check("glitch busy c0", 32'(busy), 32'(1));
    wait_stb(3);
    rxd = 1'b1;
    wait_stb(5);
    check("glitch busy c8", 32'(busy), 32'(1));
    wait_stb(1);
    check("glitch busy c9", 32'(busy), 32'(0));
    check("glitch vld", 32'(vld), 32'(0));
    wait_stb(4);

    // Break: line low for 25 bit times gives exactly one errored word.
    drive(1'b0, 16 * 25);
    m_complete(8'h00, 1'b0, 1'b0);
    check_all("break");
    drive(1'b1, 4);
    check_all("break idle");
    do_ack(); m_ack();

    // Ack on the completion cycle: new word stays valid, no overrun.
    send_frame(8'h5A, 1'b1, 1'b0);
    m_complete(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1);
    m_complete(8'hC3, 1'b1, 1'b1);
    check_all("ackdone");
    do_ack(); m_ack();

    // Overrun, then reset during data bit 3 of 0xFF.
    send_frame(8'h11, 1'b1, 1'b0);
    m_complete(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    m_complete(8'h22, 1'b1, 1'b0);
    check_all("overrun");
    drive(1'b0, 16);
    drive(1'b1, 16 * 3);
    wait_stb(8);
    check("midframe busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_dat = 8'h00; m_vld = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    check_all("midreset");
    wait_stb(3);
    send_frame(8'h81, 1'b1, 1'b0);
    m_complete(8'h81, 1'b1, 1'b0);
    check_all("after reset");
    do_ack(); m_ack();

    // Randomized frames against the model.
    for (int r = 0; r < 24; r++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(7, 0) != 0);
      ra = ($urandom_range(3, 0) == 0);
      send_frame(rd, rs, ra);
      m_complete(rd, rs, ra);
      check_all($sformatf("rand%0d", r));
      if ($urandom_range(1, 0) == 1) begin
        do_ack(); m_ack();
        check($sformatf("rand%0d ack vld", r), 32'(vld), 32'(m_vld));
        check($sformatf("rand%0d ack ovr", r), 32'(ovr), 32'(m_ovr));
      end
    end

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is correct, 0 is a mismatch.
    do_ack(); m_ack();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par ok dat", 32'(dat), 32'(8'h07));
    check("par ok perr", 32'(perr), 32'(0));
    do_ack();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par bad perr", 32'(perr), 32'(1));
    do_ack();
    par_flip = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
